// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the 3x3 convolution sequencer
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_COEF,
    WAIT_DP,
    RD_WIN,
    DRAIN,
    DONE
  } state_e;

  localparam int NUM_TAPS  = 9;
  localparam int NUM_COEF  = 10;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int OUT_CNT   = (DEF_IMG_H - 2) * (DEF_IMG_W - 2);

  // Row and column offset of each tap inside the window; tap 0 sits in bits [1:0].
  localparam logic [17:0] TAP_ROW = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [17:0] TAP_COL = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

  function automatic int num_windows(input int img_h, input int img_w);
    return (img_h - 2) * (img_w - 2);
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// rtl/conv_sched_if.sv - memory, datapath and result-write signals of the sequencer
interface conv_sched_if;

  logic        start;
  logic        M0_R_req;
  logic [31:0] M0_addr;
  logic [31:0] M0_R_data;
  logic        coef_we;
  logic [3:0]  coef_idx;
  logic [31:0] coef_data;
  logic        dp_ready;
  logic        pix_valid;
  logic [3:0]  pix_idx;
  logic [31:0] pix_data;
  logic        pix_last;
  logic        dp_done;
  logic [3:0]  M1_W_req;
  logic [31:0] M1_addr;
  logic        finish;

  modport master (
    input  start, M0_R_data, dp_ready, dp_done,
    output M0_R_req, M0_addr, coef_we, coef_idx, coef_data,
           pix_valid, pix_idx, pix_data, pix_last, M1_W_req, M1_addr, finish
  );

  modport slave (
    output start, M0_R_data, dp_ready, dp_done,
    input  M0_R_req, M0_addr, coef_we, coef_idx, coef_data,
           pix_valid, pix_idx, pix_data, pix_last, M1_W_req, M1_addr, finish
  );

endinterface

// File: rtl/conv_win_addr.sv
// rtl/conv_win_addr.sv - window row/col and tap counters producing the M0 word index
module conv_win_addr
  import conv_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        adv,
  output logic [15:0] word_idx,
  output logic [3:0]  tap_idx,
  output logic        tap_last,
  output logic        win_last
);

  logic [4:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [3:0]  tap_q, tap_d;
  logic [15:0] r_off, c_off;

  assign tap_idx  = tap_q;
  assign tap_last = (tap_q == 4'(NUM_TAPS - 1));
  assign win_last = (row_q == 5'(IMG_H - 3)) && (col_q == 5'(IMG_W - 3));

  always_comb begin
    r_off    = 16'(TAP_ROW[{tap_q, 1'b0} +: 2]);
    c_off    = 16'(TAP_COL[{tap_q, 1'b0} +: 2]);
    word_idx = (16'(row_q) + r_off) * 16'(IMG_W) + 16'(col_q) + c_off;
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    tap_d = tap_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
      tap_d = '0;
    end else if (adv) begin
      if (tap_last) begin
        tap_d = '0;
        // Columns stop at the last position where a full 3-wide window fits.
        if (col_q == 5'(IMG_W - 3)) begin
          col_d = '0;
          row_d = row_q + 5'd1;
        end else begin
          col_d = col_q + 5'd1;
        end
      end else begin
        tap_d = tap_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      tap_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      tap_q <= tap_d;
    end
  end

endmodule

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - convolution sequencer: coefficient load, window streaming, result addressing
module conv_sched
  import conv_pkg::*;
#(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int W_BASE   = 784,
  parameter int B_BASE   = 793,
  parameter int OUT_BASE = 0
) (
  input  logic         clk,
  input  logic         rst,
  conv_sched_if.master bus
);

  localparam logic [9:0]  OUT_LAST = 10'(num_windows(IMG_H, IMG_W));
  localparam logic [15:0] W_WORD   = 16'(W_BASE);
  localparam logic [15:0] B_WORD   = 16'(B_BASE);

  state_e      state_q, state_d;
  logic [3:0]  coef_cnt_q, coef_cnt_d;
  logic        finish_q, finish_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        tag_pix_q, tag_pix_d;
  logic [3:0]  tag_idx_q, tag_idx_d;
  logic        tag_last_q, tag_last_d;
  logic        coef_we_q, coef_we_d;
  logic [3:0]  coef_idx_q, coef_idx_d;
  logic        pix_valid_q, pix_valid_d;
  logic [3:0]  pix_idx_q, pix_idx_d;
  logic        pix_last_q, pix_last_d;
  logic [9:0]  out_cnt_q, out_cnt_d;
  logic [3:0]  m1_req_q, m1_req_d;
  logic [31:0] m1_addr_q, m1_addr_d;

  logic        issue, issue_pix, issue_last;
  logic [15:0] issue_word;
  logic [3:0]  issue_idx;
  logic [3:0]  coef_sel;
  logic [15:0] coef_word;
  logic        pending, accept;
  logic        win_clear, win_adv, win_tap_last, win_last;
  logic [15:0] win_word;
  logic [3:0]  win_tap;

  conv_win_addr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_win_addr (
    .clk      (clk),
    .rst      (rst),
    .clear    (win_clear),
    .adv      (win_adv),
    .word_idx (win_word),
    .tap_idx  (win_tap),
    .tap_last (win_tap_last),
    .win_last (win_last)
  );

  // The first coefficient read goes out with the start pulse, so IDLE always selects weight 0.
  assign coef_sel  = (state_q == IDLE) ? 4'd0 : coef_cnt_q;
  assign coef_word = (coef_sel < 4'(NUM_TAPS)) ? (W_WORD + 16'(coef_sel)) : B_WORD;
  assign pending   = req_q | coef_we_q | pix_valid_q;

  always_comb begin
    state_d    = state_q;
    coef_cnt_d = coef_cnt_q;
    finish_d   = finish_q;
    issue      = 1'b0;
    issue_pix  = 1'b0;
    issue_last = 1'b0;
    issue_word = '0;
    issue_idx  = '0;
    win_clear  = 1'b0;
    win_adv    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          finish_d   = 1'b0;
          win_clear  = 1'b1;
          coef_cnt_d = 4'd1;
          issue      = 1'b1;
          issue_word = coef_word;
          issue_idx  = coef_sel;
          state_d    = LD_COEF;
        end
      end
      LD_COEF: begin
        issue      = 1'b1;
        issue_word = coef_word;
        issue_idx  = coef_sel;
        coef_cnt_d = coef_cnt_q + 4'd1;
        if (coef_cnt_q == 4'(NUM_COEF - 1)) state_d = WAIT_DP;
      end
      WAIT_DP: begin
        // Tap 0 leaves on the accepting cycle so a window costs exactly nine issue cycles.
        if (bus.dp_ready && !pending) begin
          issue      = 1'b1;
          issue_pix  = 1'b1;
          issue_word = win_word;
          issue_idx  = win_tap;
          issue_last = win_tap_last;
          win_adv    = 1'b1;
          state_d    = RD_WIN;
        end
      end
      RD_WIN: begin
        issue      = 1'b1;
        issue_pix  = 1'b1;
        issue_word = win_word;
        issue_idx  = win_tap;
        issue_last = win_tap_last;
        win_adv    = 1'b1;
        if (win_tap_last) state_d = win_last ? DRAIN : WAIT_DP;
      end
      DRAIN: begin
        if (out_cnt_q == OUT_LAST) begin
          finish_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d      = issue;
    addr_d     = issue ? {14'd0, issue_word, 2'b00} : addr_q;
    tag_pix_d  = issue_pix;
    tag_idx_d  = issue_idx;
    tag_last_d = issue_last;

    coef_we_d   = req_q & ~tag_pix_q;
    coef_idx_d  = (req_q & ~tag_pix_q) ? tag_idx_q : coef_idx_q;
    pix_valid_d = req_q & tag_pix_q;
    pix_idx_d   = (req_q & tag_pix_q) ? tag_idx_q : pix_idx_q;
    pix_last_d  = req_q & tag_pix_q & tag_last_q;
  end

  // Results are only counted once coefficients are loaded and until the image is complete.
  always_comb begin
    accept    = bus.dp_done && (state_q != IDLE) && (state_q != LD_COEF) && (out_cnt_q != OUT_LAST);
    out_cnt_d = out_cnt_q;
    m1_req_d  = 4'h0;
    m1_addr_d = m1_addr_q;
    if (state_q == IDLE && bus.start) begin
      out_cnt_d = '0;
    end else if (accept) begin
      out_cnt_d = out_cnt_q + 10'd1;
      m1_req_d  = 4'hF;
      m1_addr_d = 32'(OUT_BASE) + {20'd0, out_cnt_q, 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      coef_cnt_q  <= '0;
      finish_q    <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      tag_pix_q   <= 1'b0;
      tag_idx_q   <= '0;
      tag_last_q  <= 1'b0;
      coef_we_q   <= 1'b0;
      coef_idx_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_idx_q   <= '0;
      pix_last_q  <= 1'b0;
      out_cnt_q   <= '0;
      m1_req_q    <= 4'h0;
      m1_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      coef_cnt_q  <= coef_cnt_d;
      finish_q    <= finish_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      tag_pix_q   <= tag_pix_d;
      tag_idx_q   <= tag_idx_d;
      tag_last_q  <= tag_last_d;
      coef_we_q   <= coef_we_d;
      coef_idx_q  <= coef_idx_d;
      pix_valid_q <= pix_valid_d;
      pix_idx_q   <= pix_idx_d;
      pix_last_q  <= pix_last_d;
      out_cnt_q   <= out_cnt_d;
      m1_req_q    <= m1_req_d;
      m1_addr_q   <= m1_addr_d;
    end
  end

  assign bus.M0_R_req  = req_q;
  assign bus.M0_addr   = addr_q;
  assign bus.coef_we   = coef_we_q;
  assign bus.coef_idx  = coef_idx_q;
  assign bus.coef_data = bus.M0_R_data;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_idx   = pix_idx_q;
  assign bus.pix_data  = bus.M0_R_data;
  assign bus.pix_last  = pix_last_q;
  assign bus.M1_W_req  = m1_req_q;
  assign bus.M1_addr   = m1_addr_q;
  assign bus.finish    = finish_q;

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - self-checking bench for conv_sched against a window-order model
module tb_conv_sched;
  import conv_pkg::*;

  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int W_BASE   = 784;
  localparam int B_BASE   = 793;
  localparam int OUT_BASE = 0;
  localparam int NWIN     = (IMG_H - 2) * (IMG_W - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_sched_if bus();

  conv_sched #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .W_BASE   (W_BASE),
    .B_BASE   (B_BASE),
    .OUT_BASE (OUT_BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int m0_cnt = 0, coef_cnt = 0, pix_cnt = 0, m1_cnt = 0;
  int exp_m0[$];
  int exp_pix[$];
  int m0_log[$];
  int dq[$];
  logic prev_req = 1'b0;
  logic [31:0] last_m1 = '0;
  int w1[9]  = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
  int w26[9] = '{25, 26, 27, 53, 54, 55, 81, 82, 83};
  int n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    tests++;
    fails++;
    $display("FAIL %s: got %0d, required no such event at cycle %0d", name, act, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Expected read order: 9 weights, bias, then every window row-major with its taps row-major.
  task automatic build_model();
    exp_m0.delete();
    exp_pix.delete();
    m0_log.delete();
    m0_cnt = 0; coef_cnt = 0; pix_cnt = 0; m1_cnt = 0;
    for (int k = 0; k < 9; k++) exp_m0.push_back(W_BASE + k);
    exp_m0.push_back(B_BASE);
    for (int r0 = 0; r0 <= IMG_H - 3; r0++)
      for (int c0 = 0; c0 <= IMG_W - 3; c0++)
        for (int t = 0; t < 9; t++) begin
          exp_m0.push_back((r0 + t / 3) * IMG_W + c0 + t % 3);
          exp_pix.push_back((r0 + t / 3) * IMG_W + c0 + t % 3);
        end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_M0_R_req"}, 32'(bus.M0_R_req), 0);
    chk({tag, "_M0_addr"}, bus.M0_addr, 0);
    chk({tag, "_coef_we"}, 32'(bus.coef_we), 0);
    chk({tag, "_coef_idx"}, 32'(bus.coef_idx), 0);
    chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
    chk({tag, "_pix_idx"}, 32'(bus.pix_idx), 0);
    chk({tag, "_pix_last"}, 32'(bus.pix_last), 0);
    chk({tag, "_M1_W_req"}, 32'(bus.M1_W_req), 0);
    chk({tag, "_M1_addr"}, bus.M1_addr, 0);
    chk({tag, "_finish"}, 32'(bus.finish), 0);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  // Memory: word k holds k, data one cycle after the request.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (bus.M0_R_req) bus.M0_R_data <= bus.M0_addr >> 2;
  end

  // Per-cycle compare against the model, plus the datapath stand-in returning dp_done.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_req = 1'b0;
      dq.delete();
      bus.dp_done = 1'b0;
    end else begin
      if (bus.M0_R_req) begin
        if (exp_m0.size() == 0) fail_now("m0_extra_req", int'(bus.M0_addr));
        else chk("m0_addr", bus.M0_addr, 32'(exp_m0.pop_front() * 4));
        m0_log.push_back(int'(bus.M0_addr >> 2));
        m0_cnt++;
      end
      if (bus.coef_we) begin
        chk("coef_lag", 32'(prev_req), 1);
        chk("coef_idx", 32'(bus.coef_idx), 32'(coef_cnt));
        chk("coef_data", bus.coef_data, 32'((coef_cnt < 9) ? W_BASE + coef_cnt : B_BASE));
        coef_cnt++;
      end
      if (bus.pix_valid) begin
        chk("pix_lag", 32'(prev_req), 1);
        chk("pix_idx", 32'(bus.pix_idx), 32'(pix_cnt % 9));
        chk("pix_last", 32'(bus.pix_last), 32'(pix_cnt % 9 == 8));
        if (exp_pix.size() == 0) fail_now("pix_extra", int'(bus.pix_data));
        else chk("pix_data", bus.pix_data, 32'(exp_pix.pop_front()));
        pix_cnt++;
      end else if (bus.pix_last) begin
        fail_now("pix_last_without_valid", int'(bus.pix_idx));
      end
      if (bus.M1_W_req != 4'h0) begin
        chk("m1_strobe", 32'(bus.M1_W_req), 32'hF);
        if (m1_cnt >= NWIN) fail_now("m1_extra_write", int'(bus.M1_addr));
        else chk("m1_addr", bus.M1_addr, 32'(OUT_BASE + 4 * m1_cnt));
        last_m1 = bus.M1_addr;
        m1_cnt++;
      end
      if (bus.pix_last) dq.push_back(cyc + 5);
      if (dq.size() > 0 && dq[0] == cyc) begin
        bus.dp_done = 1'b1;
        void'(dq.pop_front());
      end else begin
        bus.dp_done = 1'b0;
      end
      prev_req = bus.M0_R_req;
    end
  end

  initial begin
    bus.start    = 1'b0;
    bus.dp_ready = 1'b1;
    repeat (3) step();
    check_reset("reset");
    rst = 1'b0;
    step();

    build_model();
    pulse_start();
    n = 0;
    while (m0_cnt < 19 && n < 200) begin step(); n++; end
    if (m0_cnt < 19) fail_now("timeout_window1", m0_cnt);

    bus.dp_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_no_req", 32'(bus.M0_R_req), 0);
      chk("bp_state", 32'(dut.state_q), 32'(WAIT_DP));
    end
    bus.dp_ready = 1'b1;
    step();
    chk("bp_resume_req", 32'(bus.M0_R_req), 1);
    chk("bp_resume_addr", bus.M0_addr, 4);

    n = 0;
    while (!bus.finish && n < 20000) begin step(); n++; end
    if (!bus.finish) fail_now("timeout_finish", m1_cnt);
    chk("m1_total", 32'(m1_cnt), 676);
    chk("m1_last_addr", last_m1, 2700);
    chk("pix_total", 32'(pix_cnt), 676 * 9);
    chk("coef_total", 32'(coef_cnt), 10);
    chk("m0_left", 32'(exp_m0.size()), 0);
    chk("coef_first_word", 32'(m0_log[0]), 784);
    chk("bias_word", 32'(m0_log[9]), 793);
    for (int i = 0; i < 9; i++) begin
      chk("win1_word", 32'(m0_log[10 + i]), 32'(w1[i]));
      chk("win26_word", 32'(m0_log[10 + 25 * 9 + i]), 32'(w26[i]));
    end
    chk("win27_base", 32'(m0_log[10 + 26 * 9]), 28);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("finish_hold", 32'(bus.finish), 1);
    end

    build_model();
    pulse_start();
    chk("finish_cleared", 32'(bus.finish), 0);
    n = 0;
    while (pix_cnt < 99 * 9 + 4 && n < 3000) begin step(); n++; end
    if (pix_cnt < 99 * 9 + 4) fail_now("timeout_window100", pix_cnt);
    rst = 1'b1;
    #1;
    check_reset("midrun_reset");
    step();
    rst = 1'b0;
    build_model();
    step();

    pulse_start();
    chk("restart_req", 32'(bus.M0_R_req), 1);
    chk("restart_addr", bus.M0_addr, 3136);
    n = 0;
    while (m0_cnt < 19 && n < 200) begin step(); n++; end
    if (m0_cnt < 19) fail_now("timeout_restart", m0_cnt);
    chk("restart_coef_total", 32'(coef_cnt), 10);
    chk("restart_first_word", 32'(m0_log[0]), 784);
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
